// File: rtl/rf_pkg.sv
// Shared register-file write-port definitions: widths and the queued write request type.
package rf_pkg;

    localparam int XLEN      = 32;
    localparam int ADDR_SIZE = 5;
    localparam int REG_NUM   = 1 << ADDR_SIZE;

    typedef struct packed {
        logic [ADDR_SIZE-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Synchronous FIFO of pending long-latency register writes.
// Exposes per-slot valid/rd so the top can flag RAW hazards on queued results.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            push_i,
    input  wb_req_t                         push_data_i,
    input  logic                            pop_i,
    output wb_req_t                         head_o,
    output logic [$clog2(DEPTH+1)-1:0]      count_o,
    output logic [DEPTH-1:0]                ent_valid_o,
    output logic [DEPTH-1:0][ADDR_SIZE-1:0] ent_rd_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t          mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_comb begin
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = ptr_inc(rd_ptr_q);
        end
        if (do_push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = ptr_inc(wr_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign ent_valid_o = valid_q;

    always_comb begin
        ent_rd_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_rd_o[i] = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: pipeline WB wins, queued long-latency results fill idle slots.
// Forces a pipeline bubble when the queue is full or its head has waited too long.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         WB_we,
    input  logic [ADDR_SIZE-1:0]         WB_rd,
    input  logic [XLEN-1:0]              WB_data,
    input  logic                         LL_valid,
    input  logic [ADDR_SIZE-1:0]         LL_rd,
    input  logic [XLEN-1:0]              LL_data,
    output logic                         LL_ready,
    output logic                         RF_we,
    output logic [ADDR_SIZE-1:0]         RF_rd,
    output logic [XLEN-1:0]              RF_data,
    output logic                         P_stall,
    input  logic [ADDR_SIZE-1:0]         D_ra,
    input  logic [ADDR_SIZE-1:0]         D_rb,
    output logic                         D_pend_a,
    output logic                         D_pend_b,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AGE_W = $clog2(MAX_WAIT + 1);

    wb_req_t                         head;
    wb_req_t                         push_req;
    logic [CNT_W-1:0]                count;
    logic [CNT_W-1:0]                count_d;
    logic [DEPTH-1:0]                ent_valid;
    logic [DEPTH-1:0][ADDR_SIZE-1:0] ent_rd;
    logic                            wb_sel, push, pop;
    logic [AGE_W-1:0]                age_q, age_d;
    logic                            p_stall_q, p_stall_d;

    // A write to x0 is a free slot; an LL result for x0 is accepted but never queued.
    assign wb_sel   = WB_we && (WB_rd != '0);
    assign LL_ready = (count < CNT_W'(DEPTH));
    assign push     = !rst && LL_valid && LL_ready && (LL_rd != '0);
    assign pop      = !rst && !wb_sel && (count != '0);

    assign push_req.rd   = LL_rd;
    assign push_req.data = LL_data;

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push),
        .push_data_i(push_req),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (count),
        .ent_valid_o(ent_valid),
        .ent_rd_o   (ent_rd)
    );

    always_comb begin
        RF_we   = 1'b0;
        RF_rd   = '0;
        RF_data = '0;
        if (!rst) begin
            if (wb_sel) begin
                RF_we   = 1'b1;
                RF_rd   = WB_rd;
                RF_data = WB_data;
            end else if (pop) begin
                RF_we   = 1'b1;
                RF_rd   = head.rd;
                RF_data = head.data;
            end
        end
    end

    always_comb begin
        count_d = count + CNT_W'(push) - CNT_W'(pop);
        if ((count_d == '0) || pop) begin
            age_d = '0;
        end else if (age_q >= AGE_W'(MAX_WAIT)) begin
            age_d = AGE_W'(MAX_WAIT);
        end else begin
            age_d = age_q + 1'b1;
        end
        p_stall_d = (count_d != '0) &&
                    ((age_d >= AGE_W'(MAX_WAIT)) || (count_d == CNT_W'(DEPTH)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q     <= '0;
            p_stall_q <= 1'b0;
        end else begin
            age_q     <= age_d;
            p_stall_q <= p_stall_d;
        end
    end

    assign P_stall  = p_stall_q;
    assign fifo_cnt = count;

    // Only committed entries count; a same-cycle push is not yet visible to decode.
    always_comb begin
        D_pend_a = 1'b0;
        D_pend_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i] && (ent_rd[i] == D_ra) && (D_ra != '0)) D_pend_a = 1'b1;
            if (ent_valid[i] && (ent_rd[i] == D_rb) && (D_rb != '0)) D_pend_b = 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: queue-based reference model plus directed literal checks.
module tb_rf_wb_arbiter;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_we;
    logic [4:0]  WB_rd;
    logic [31:0] WB_data;
    logic        LL_valid;
    logic [4:0]  LL_rd;
    logic [31:0] LL_data;
    logic        LL_ready;
    logic        RF_we;
    logic [4:0]  RF_rd;
    logic [31:0] RF_data;
    logic        P_stall;
    logic [4:0]  D_ra, D_rb;
    logic        D_pend_a, D_pend_b;
    logic [2:0]  fifo_cnt;

    rf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .WB_we(WB_we), .WB_rd(WB_rd), .WB_data(WB_data),
        .LL_valid(LL_valid), .LL_rd(LL_rd), .LL_data(LL_data), .LL_ready(LL_ready),
        .RF_we(RF_we), .RF_rd(RF_rd), .RF_data(RF_data),
        .P_stall(P_stall),
        .D_ra(D_ra), .D_rb(D_rb), .D_pend_a(D_pend_a), .D_pend_b(D_pend_b),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t m_q[$];
    int   m_age   = 0;
    bit   m_stall = 1'b0;
    bit   chk_en  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending writes, an integer head-wait counter and a stall bit.
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_age   = 0;
            m_stall = 1'b0;
        end else begin
            automatic bit win  = WB_we && (WB_rd != 0);
            automatic bit pop  = !win && (m_q.size() > 0);
            automatic bit push = LL_valid && (m_q.size() < DEPTH) && (LL_rd != 0);
            automatic ent_t e;
            automatic int n;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                e.rd   = LL_rd;
                e.data = LL_data;
                m_q.push_back(e);
            end
            n = m_q.size();
            if (n == 0 || pop) m_age = 0;
            else if (m_age < MAX_WAIT) m_age = m_age + 1;
            m_stall = (n != 0) && ((m_age >= MAX_WAIT) || (n == DEPTH));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit          e_we = 1'b0;
            automatic logic [4:0]  e_rd = '0;
            automatic logic [31:0] e_data = '0;
            automatic bit          e_pa = 1'b0;
            automatic bit          e_pb = 1'b0;
            if (!rst) begin
                if (WB_we && WB_rd != 0) begin
                    e_we = 1'b1; e_rd = WB_rd; e_data = WB_data;
                end else if (m_q.size() > 0) begin
                    e_we = 1'b1; e_rd = m_q[0].rd; e_data = m_q[0].data;
                end
            end
            foreach (m_q[i]) begin
                if (D_ra != 0 && m_q[i].rd == D_ra) e_pa = 1'b1;
                if (D_rb != 0 && m_q[i].rd == D_rb) e_pb = 1'b1;
            end
            chk("RF_we", RF_we, e_we);
            chk("RF_rd", RF_rd, e_rd);
            chk("RF_data", RF_data, e_data);
            chk("LL_ready", LL_ready, m_q.size() < DEPTH);
            chk("fifo_cnt", fifo_cnt, m_q.size());
            chk("P_stall", P_stall, m_stall);
            chk("D_pend_a", D_pend_a, e_pa);
            chk("D_pend_b", D_pend_b, e_pb);
            chk("protocol WB_we under P_stall", WB_we & P_stall, 0);
        end
    end

    // Drives one cycle's inputs just after the edge and returns at mid-cycle, where outputs are sampled.
    task automatic apply(input bit r, input bit wbw, input logic [4:0] wrd, input logic [31:0] wd,
                         input bit llv, input logic [4:0] lrd, input logic [31:0] ld,
                         input logic [4:0] ra, input logic [4:0] rb);
        @(posedge clk);
        #1;
        rst      = r;
        WB_we    = wbw && !m_stall;
        WB_rd    = wrd;
        WB_data  = wd;
        LL_valid = llv;
        LL_rd    = lrd;
        LL_data  = ld;
        D_ra     = ra;
        D_rb     = rb;
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] ra);
        apply(0, 0, 0, 0, 0, 0, 0, ra, 0);
    endtask

    initial begin
        rst = 1'b1; WB_we = 1'b0; WB_rd = '0; WB_data = '0;
        LL_valid = 1'b0; LL_rd = '0; LL_data = '0; D_ra = '0; D_rb = '0;
        @(posedge clk);
        chk_en = 1'b1;

        // reset: pipeline write must not reach the regfile while rst is high
        apply(1, 1, 5, 32'h55, 0, 0, 0, 0, 0);
        apply(1, 1, 5, 32'h55, 0, 0, 0, 0, 0);
        chk("rst RF_we", RF_we, 0);
        chk("rst fifo_cnt", fifo_cnt, 0);
        chk("rst LL_ready", LL_ready, 1);
        chk("rst P_stall", P_stall, 0);

        // 1) single LL result, no bypass
        apply(0, 0, 0, 0, 1, 3, 32'hAA, 0, 0);
        chk("t1 no bypass RF_we", RF_we, 0);
        idle(0);
        chk("t1 RF_we", RF_we, 1);
        chk("t1 RF_rd", RF_rd, 3);
        chk("t1 RF_data", RF_data, 32'hAA);
        chk("t1 cnt1", fifo_cnt, 1);
        idle(0);
        chk("t1 cnt0", fifo_cnt, 0);

        // 2) fill the queue under continuous WB traffic
        for (int i = 0; i < 4; i++) begin
            apply(0, 1, 5, 32'h55, 1, 5'(10 + i), 32'h100 + i, 0, 0);
        end
        chk("t2 cnt3", fifo_cnt, 3);
        apply(0, 1, 5, 32'h55, 0, 0, 0, 0, 0);
        chk("t2 full LL_ready", LL_ready, 0);
        chk("t2 P_stall", P_stall, 1);
        chk("t2 bubble WB_we", WB_we, 0);
        chk("t2 head rd", RF_rd, 10);
        chk("t2 head data", RF_data, 32'h100);
        apply(0, 1, 5, 32'h55, 0, 0, 0, 0, 0);
        chk("t2 stall cleared", P_stall, 0);
        chk("t2 LL_ready back", LL_ready, 1);
        chk("t2 cnt after bubble", fifo_cnt, 3);
        for (int i = 0; i < 3; i++) begin
            idle(0);
            chk("t2 drain order", RF_rd, 5'(11 + i));
        end
        idle(0);
        chk("t2 drained", fifo_cnt, 0);

        // 3) head ages out under busy WB
        apply(0, 1, 5, 32'h55, 1, 9, 32'h99, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            apply(0, 1, 5, 32'h55, 0, 0, 0, 0, 0);
            chk("t3 P_stall age", P_stall, (k == 8));
        end
        chk("t3 aged pop rd", RF_rd, 9);
        apply(0, 1, 5, 32'h55, 0, 0, 0, 0, 0);
        chk("t3 stall released", P_stall, 0);
        chk("t3 cnt", fifo_cnt, 0);
        chk("t3 WB wins", RF_rd, 5);

        // 4) pending flags
        apply(0, 1, 5, 32'h55, 1, 7, 32'h77, 7, 0);
        chk("t4 no same-cycle pend", D_pend_a, 0);
        apply(0, 1, 5, 32'h55, 0, 0, 0, 7, 0);
        chk("t4 pend_a", D_pend_a, 1);
        idle(7);
        chk("t4 pend until pop", D_pend_a, 1);
        chk("t4 pop rd", RF_rd, 7);
        idle(7);
        chk("t4 pend cleared", D_pend_a, 0);
        apply(0, 0, 0, 0, 1, 0, 32'h5A, 0, 0);
        chk("t4 x0 pend", D_pend_a, 0);
        idle(0);
        chk("t4 x0 not queued", fifo_cnt, 0);
        apply(0, 1, 5, 32'h55, 1, 7, 32'h78, 0, 7);
        apply(0, 1, 5, 32'h55, 0, 0, 0, 0, 7);
        chk("t4 pend_b", D_pend_b, 1);
        chk("t4 ra=0 pend_a", D_pend_a, 0);
        idle(0);

        // 5) WB to x0 frees the slot; push+pop keeps count
        apply(0, 1, 5, 32'h55, 1, 14, 32'hE, 0, 0);
        apply(0, 1, 5, 32'h55, 1, 15, 32'hF, 0, 0);
        apply(0, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0);
        chk("t5 cnt2", fifo_cnt, 2);
        chk("t5 x0 slot rd", RF_rd, 14);
        chk("t5 x0 slot data", RF_data, 32'hE);
        apply(0, 0, 0, 0, 1, 16, 32'h10, 0, 0);
        chk("t5 pushpop rd", RF_rd, 15);
        idle(0);
        chk("t5 cnt unchanged", fifo_cnt, 1);
        chk("t5 next rd", RF_rd, 16);

        // 6) reset drops queued results
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 5, 32'h55, 1, 5'(20 + i), 32'h200 + i, 0, 0);
        end
        apply(1, 1, 5, 32'h55, 0, 0, 0, 20, 0);
        chk("t6 cnt3", fifo_cnt, 3);
        chk("t6 rst RF_we", RF_we, 0);
        idle(20);
        chk("t6 cnt0", fifo_cnt, 0);
        chk("t6 RF_we", RF_we, 0);
        chk("t6 P_stall", P_stall, 0);
        chk("t6 D_pend", D_pend_a, 0);

        // mixed traffic, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
